// File: rtl/axi_fetch_queue.sv
// Instruction fetch front end: issues single-word AXI reads, tracks them in order,
// buffers returned instructions for decode and discards reads made stale by a redirect.
module axi_fetch_queue #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc00000,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUT    = 2,
    parameter logic [3:0]  FETCH_ID   = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        decode_allowin,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [2:0]  arsize,
    input  logic        rvalid,
    output logic        rready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata
);

    localparam int unsigned FPW = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned QPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned OW  = $clog2(MAX_OUT + 1);

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    araddr_q, araddr_d;
    logic           arvalid_q, arvalid_d;
    logic           stale_q, stale_d;
    logic           halt_q, halt_d;
    logic [OW-1:0]  out_q, out_d;
    logic [OW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FPW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [QPW-1:0] qwr_q, qwr_d, qrd_q, qrd_d;

    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];
    logic        fifo_adel [DEPTH];
    logic [31:0] pcq       [MAX_OUT];

    logic        ar_hs, r_hs, r_push, adel_go, fifo_push, fifo_pop;
    logic [31:0] push_pc, push_inst;
    logic        push_adel;

    always_comb begin
        ar_hs    = arvalid_q && arready;
        r_hs     = rvalid && (rid == FETCH_ID);
        r_push   = r_hs && (drop_q == '0) && !redirect_valid;
        // Misaligned fault entry waits until every live read has landed so order is kept.
        adel_go  = !redirect_valid && !halt_q && (fetch_pc_q[1:0] != 2'b00) && !arvalid_q &&
                   (out_q == drop_q) && (32'(cnt_q) < DEPTH) && !r_push;
        fifo_push = r_push || adel_go;
        fifo_pop  = (cnt_q != '0) && decode_allowin && !redirect_valid;

        push_pc   = r_push ? pcq[qrd_q] : fetch_pc_q;
        push_inst = r_push ? rdata : 32'd0;
        push_adel = !r_push;

        out_d = out_q;
        if (ar_hs && !r_hs)      out_d = out_q + OW'(1);
        else if (!ar_hs && r_hs) out_d = out_q - OW'(1);

        drop_d = drop_q;
        if (redirect_valid)                drop_d = out_q - OW'(r_hs) + OW'(arvalid_q);
        else if (r_hs && (drop_q != '0))   drop_d = drop_q - OW'(1);

        // An AR left pending across a redirect belongs to the old path: its
        // acceptance must not advance the new fetch_pc.
        stale_d = stale_q;
        if (ar_hs) stale_d = 1'b0;
        if (redirect_valid && arvalid_q && !arready) stale_d = 1'b1;

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)         fetch_pc_d = redirect_pc;
        else if (ar_hs && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;

        halt_d = halt_q;
        if (redirect_valid) halt_d = 1'b0;
        else if (adel_go)   halt_d = 1'b1;

        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (redirect_valid) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            if (fifo_push && !fifo_pop)      cnt_d = cnt_q + CW'(1);
            else if (!fifo_push && fifo_pop) cnt_d = cnt_q - CW'(1);
            if (fifo_push) wr_d = wr_q + FPW'(1);
            if (fifo_pop)  rd_d = rd_q + FPW'(1);
        end

        qwr_d = qwr_q;
        qrd_d = qrd_q;
        if (ar_hs) qwr_d = (qwr_q == QPW'(MAX_OUT - 1)) ? '0 : qwr_q + QPW'(1);
        if (r_hs)  qrd_d = (qrd_q == QPW'(MAX_OUT - 1)) ? '0 : qrd_q + QPW'(1);

        arvalid_d = 1'b0;
        araddr_d  = araddr_q;
        if (arvalid_q && !arready) begin
            arvalid_d = 1'b1;
        end else if (!redirect_valid && !halt_d && (fetch_pc_d[1:0] == 2'b00) &&
                     (32'(out_d) < MAX_OUT) &&
                     ((32'(out_d) - 32'(drop_d) + 32'(cnt_d)) < DEPTH)) begin
            arvalid_d = 1'b1;
            araddr_d  = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_ADDR;
            araddr_q   <= RESET_ADDR;
            arvalid_q  <= 1'b0;
            stale_q    <= 1'b0;
            halt_q     <= 1'b0;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            qwr_q      <= '0;
            qrd_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            stale_q    <= stale_d;
            halt_q     <= halt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            qwr_q      <= qwr_d;
            qrd_q      <= qrd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc[wr_q]   <= push_pc;
            fifo_inst[wr_q] <= push_inst;
            fifo_adel[wr_q] <= push_adel;
        end
        if (ar_hs) pcq[qwr_q] <= araddr_q;
    end

    assign out_valid = (cnt_q != '0);
    assign out_pc    = fifo_pc[rd_q];
    assign out_inst  = fifo_inst[rd_q];
    assign out_adel  = fifo_adel[rd_q];
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign arid      = FETCH_ID;
    assign arsize    = 3'd2;
    assign rready    = r_hs;

endmodule

// File: tb/tb_axi_fetch_queue.sv
// Bench for axi_fetch_queue: randomized AXI slave plus a sequential-PC reference stream.
module tb_axi_fetch_queue;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        decode_allowin = 1'b0;
    logic        out_valid, out_adel, arvalid, rready;
    logic [31:0] out_pc, out_inst, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;

    always #5 clk = ~clk;

    axi_fetch_queue #(.RESET_ADDR(RST_PC), .DEPTH(4), .MAX_OUT(3), .FETCH_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .decode_allowin(decode_allowin), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_adel(out_adel), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arid(arid), .arsize(arsize), .rvalid(rvalid), .rready(rready),
        .rid(rid), .rdata(rdata));

    int n_cmp = 0;
    int n_err = 0;

    int ar_pct = 100, r_pct = 100, foreign_pct = 0, ar_cap = 1000000;
    bit r_hold = 1'b0;
    logic [31:0] pend_q[$];
    logic [31:0] ar_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hbfc00000) return 32'h24010001;
        return a ^ 32'h13572468;
    endfunction

    // AXI slave: beats return in order, never in the same cycle as their AR.
    initial begin : slave
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend_q.delete();
                ar_log.delete();
                arready = 1'b0;
                rvalid  = 1'b0;
            end else begin
                if (pend_q.size() > 0 && !r_hold && int'($urandom_range(99)) < r_pct) begin
                    rvalid = 1'b1;
                    rid    = 4'd0;
                    rdata  = mem_word(pend_q.pop_front());
                end else if (int'($urandom_range(99)) < foreign_pct) begin
                    rvalid = 1'b1;
                    rid    = 4'd1;
                    rdata  = $urandom;
                end else begin
                    rvalid = 1'b0;
                    rid    = 4'($urandom_range(15));
                    rdata  = $urandom;
                end
                arready = (ar_log.size() < ar_cap) && (int'($urandom_range(99)) < ar_pct);
                if (arvalid && arready) begin
                    pend_q.push_back(araddr);
                    ar_log.push_back(araddr);
                end
            end
        end
    end

    task automatic set_slave(input int ap, input int rp, input int fp);
        ar_pct = ap; r_pct = rp; foreign_pct = fp; r_hold = 1'b0; ar_cap = 1000000;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b0; redirect_valid = 1'b0; decode_allowin = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        set_slave(100, 100, 0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (araddr !== RST_PC) begin n_err++; $display("FAIL reset_araddr: got %h want %h", araddr, RST_PC); end
        n_cmp++; if (arid !== 4'd0 || arsize !== 3'd2) begin n_err++; $display("FAIL reset_arid_arsize: got %h/%h want 0/2", arid, arsize); end
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #2;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== RST_PC) begin n_err++; $display("FAIL release_ar: got %b/%h want 1/%h", arvalid, araddr, RST_PC); end
    endtask

    task automatic test_first_fetch();
        int first;
        set_slave(100, 100, 0);
        do_reset();
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #2;
            if (out_valid && first == 0) first = i;
        end
        n_cmp++; if (first != 3) begin n_err++; $display("FAIL first_latency: got %0d want 3", first); end
        n_cmp++; if (out_pc !== RST_PC || out_inst !== 32'h24010001 || out_adel !== 1'b0) begin
            n_err++; $display("FAIL first_entry: got %h/%h/%b want %h/24010001/0", out_pc, out_inst, out_adel, RST_PC); end
        n_cmp++; if (ar_log.size() == 0 || ar_log[0] !== RST_PC) begin
            n_err++; $display("FAIL first_araddr: got %h (n=%0d) want %h", (ar_log.size() > 0) ? ar_log[0] : 32'hx, ar_log.size(), RST_PC); end
    endtask

    task automatic test_buffer_full();
        logic [31:0] want;
        set_slave(100, 100, 0);
        do_reset();
        repeat (30) @(negedge clk);
        #2;
        n_cmp++; if (ar_log.size() != 4) begin n_err++; $display("FAIL full_ar_count: got %0d want 4", ar_log.size()); end
        n_cmp++; if (arvalid !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL full_flags: got arvalid=%b out_valid=%b want 0/1", arvalid, out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            decode_allowin = 1'b1;
            #2;
            want = RST_PC + 32'(i * 4);
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== want || out_inst !== mem_word(want)) begin
                n_err++; $display("FAIL drain_%0d: got %b/%h/%h want 1/%h/%h", i, out_valid, out_pc, out_inst, want, mem_word(want)); end
        end
        @(negedge clk);
        decode_allowin = 1'b0;
    endtask

    task automatic test_redirect_drop();
        bit found;
        int nseen;
        logic [31:0] want;
        set_slave(100, 100, 0);
        ar_cap = 2; r_hold = 1'b1;
        do_reset();
        decode_allowin = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #2;
            if (arvalid && !arready && ar_log.size() == 2) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL drop_setup: got no pending third AR want pending"); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00100;
        @(negedge clk);
        redirect_valid = 1'b0; ar_cap = 1000000; r_hold = 1'b0;
        #2;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'hbfc00008) begin
            n_err++; $display("FAIL drop_ar_held: got %b/%h want 1/bfc00008", arvalid, araddr); end
        nseen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (out_valid && decode_allowin) begin
                want = 32'hbfc00100 + 32'(nseen * 4);
                n_cmp++; if (out_pc !== want || out_inst !== mem_word(want) || out_adel !== 1'b0) begin
                    n_err++; $display("FAIL drop_stream_%0d: got %h/%h want %h/%h", nseen, out_pc, out_inst, want, mem_word(want)); end
                nseen++;
            end
        end
        n_cmp++; if (nseen < 3) begin n_err++; $display("FAIL drop_progress: got %0d want >=3", nseen); end
        n_cmp++; if (ar_log.size() < 4 || ar_log[2] !== 32'hbfc00008 || ar_log[3] !== 32'hbfc00100) begin
            n_err++; $display("FAIL drop_ar_order: got n=%0d want [2]=bfc00008 [3]=bfc00100", ar_log.size()); end
        decode_allowin = 1'b0;
    endtask

    task automatic test_misaligned();
        int n0, nseen;
        set_slave(100, 100, 0);
        do_reset();
        repeat (10) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00102;
        n0 = ar_log.size();
        @(negedge clk);
        redirect_valid = 1'b0; decode_allowin = 1'b1;
        nseen = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (out_valid) begin
                n_cmp++; if (nseen != 0 || out_pc !== 32'hbfc00102 || out_adel !== 1'b1 || out_inst !== 32'd0) begin
                    n_err++; $display("FAIL adel_entry_%0d: got %h/%h/%b want bfc00102/0/1 once", nseen, out_pc, out_inst, out_adel); end
                nseen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (nseen != 1) begin n_err++; $display("FAIL adel_count: got %0d want 1", nseen); end
        n_cmp++; if (ar_log.size() > n0 + 1) begin n_err++; $display("FAIL adel_halt_ar: got %0d new ARs want <=1", ar_log.size() - n0); end
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00200;
        @(negedge clk);
        redirect_valid = 1'b0;
        nseen = 0;
        for (int i = 0; i < 30; i++) begin
            #2;
            if (out_valid && nseen == 0) begin
                n_cmp++; if (out_pc !== 32'hbfc00200 || out_adel !== 1'b0 || out_inst !== mem_word(32'hbfc00200)) begin
                    n_err++; $display("FAIL adel_resume: got %h/%b want bfc00200/0", out_pc, out_adel); end
                nseen++;
            end
            @(negedge clk);
        end
        n_cmp++; if (nseen == 0) begin n_err++; $display("FAIL adel_resume_progress: got 0 entries want >=1"); end
        decode_allowin = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr;
        bit prev_pend;
        int consumed;
        set_slave(70, 60, 30);
        do_reset();
        exp_pc = RST_PC; prev_pend = 1'b0; prev_addr = 32'd0; consumed = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            decode_allowin = (int'($urandom_range(99)) < 70);
            redirect_valid = (int'($urandom_range(99)) < 3);
            if (redirect_valid) redirect_pc = RST_PC + ($urandom_range(1023) << 2);
            #2;
            n_cmp++; if (rready !== (rvalid && rid == 4'd0)) begin
                n_err++; $display("FAIL rand_rready: got %b want %b (rid=%0d)", rready, rvalid && rid == 4'd0, rid); end
            if (prev_pend) begin
                n_cmp++; if (arvalid !== 1'b1 || araddr !== prev_addr) begin
                    n_err++; $display("FAIL rand_ar_stable: got %b/%h want 1/%h", arvalid, araddr, prev_addr); end
            end
            prev_pend = arvalid && !arready;
            prev_addr = araddr;
            if (out_valid && decode_allowin && !redirect_valid) begin
                n_cmp++; if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc) || out_adel !== 1'b0) begin
                    n_err++; $display("FAIL rand_stream_%0d: got %h/%h/%b want %h/%h/0", consumed, out_pc, out_inst, out_adel, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
        end
        @(negedge clk);
        redirect_valid = 1'b0; decode_allowin = 1'b0;
        n_cmp++; if (consumed < 50) begin n_err++; $display("FAIL rand_progress: got %0d want >=50", consumed); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int nseen;
        set_slave(100, 60, 0);
        decode_allowin = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #2;
            if (out_valid && arvalid) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL mid_setup: got no busy cycle want out_valid&&arvalid"); end
        @(negedge clk); #1 rst = 1'b0;
        #1;
        n_cmp++; if (arvalid !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_outputs: got %b/%b want 0/0", arvalid, out_valid); end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        nseen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (out_valid && nseen == 0) begin
                n_cmp++; if (out_pc !== RST_PC || out_inst !== 32'h24010001) begin
                    n_err++; $display("FAIL mid_restart: got %h/%h want %h/24010001", out_pc, out_inst, RST_PC); end
                nseen++;
            end
        end
        n_cmp++; if (nseen == 0 || ar_log.size() == 0 || ar_log[0] !== RST_PC) begin
            n_err++; $display("FAIL mid_restart_ar: got seen=%0d n=%0d want first AR %h", nseen, ar_log.size(), RST_PC); end
        decode_allowin = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_buffer_full();
        test_redirect_drop();
        test_misaligned();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_fetch_queue.md
AXI_FETCH_QUEUE -- requirements
Module: axi_fetch_queue

Interface
REQ-001 Parameter: RESET_ADDR, 32'hbfc00000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 4, instruction buffer entries; power of 2, minimum 2.
REQ-003 Parameter: MAX_OUT, 2, maximum AXI reads in flight; minimum 1.
REQ-004 Parameter: FETCH_ID, 4'd0, AXI ID used for all fetch reads.
REQ-005 Port: clk, input, 1, clock; all state changes on the rising edge.
REQ-006 Port: rst, input, 1; one clock, reset is asynchronous and active-low.
REQ-007 Port: redirect_valid, input, 1, branch or exception redirect strobe.
REQ-008 Port: redirect_pc, input, 32, new fetch address.
REQ-009 Port: decode_allowin, input, 1, decode stage accepts an instruction.
REQ-010 Port: out_valid / out_pc / out_inst / out_adel, output, 1/32/32/1, head instruction to decode.
REQ-011 Port: arvalid / arready / araddr / arid / arsize, out/in/out/out/out, 1/1/32/4/3, AXI read-address channel.
REQ-012 Port: rvalid / rready / rid / rdata, in/out/in/in, 1/1/4/32, AXI read-data channel (shared with data side).

Function
REQ-013 The block SHALL hold fetch_pc, issue one AR per instruction with araddr=fetch_pc, arsize=3'd2, arid=FETCH_ID, and advance fetch_pc by 4 on each AR handshake.
REQ-014 The block SHALL hold araddr, arid and arvalid stable from arvalid rise until arready; redirect SHALL NOT retract a pending AR.
REQ-015 The block SHALL assert arvalid only when outstanding<MAX_OUT, (outstanding-drop_cnt)+fifo_count<DEPTH, no redirect this cycle, and fetch is not halted.
REQ-016 The block SHALL drive rready = rvalid && rid==FETCH_ID; other IDs are ignored and never block.
REQ-017 The block SHALL keep an in-order queue of issued PCs (MAX_OUT deep), pushed on AR handshake and popped on each fetch R handshake.
REQ-018 On a fetch R handshake with drop_cnt==0, the block SHALL push {pc, rdata, adel=0} into the instruction FIFO.
REQ-019 On a fetch R handshake with drop_cnt>0, the block SHALL discard the data and decrement drop_cnt.
REQ-020 out_valid SHALL equal FIFO non-empty; out_pc, out_inst and out_adel SHALL show the head entry; pop on out_valid && decode_allowin.
REQ-021 A simultaneous push and pop SHALL both take effect, leaving the count unchanged; a pop when empty or a push when full SHALL be impossible by construction.
REQ-022 Redirect actions:
- flush the FIFO to empty;
- set fetch_pc <= redirect_pc;
- clear halt;
- set drop_cnt <= outstanding - (R handshake this cycle) + (AR pending or accepted this cycle).
REQ-023 On redirect, push and pop in the same cycle SHALL be cancelled; redirect has priority.
REQ-024 If fetch_pc[1:0]!=0 and no AR is pending, the block SHALL issue no AR, push {fetch_pc, 32'd0, adel=1} once FIFO space allows, then halt until redirect.
REQ-025 outstanding SHALL increment on AR handshake and decrement on fetch R handshake; both in one cycle SHALL leave it unchanged.
REQ-026 Latency: AR handshake at cycle N with R at cycle M SHALL give out_valid at M+1 if the FIFO was empty.

Reset
REQ-027 While rst=0, outputs SHALL be: arvalid=0, out_valid=0, araddr=RESET_ADDR, arid=FETCH_ID, arsize=3'd2.
REQ-028 While rst=0, internal state SHALL be: fetch_pc=RESET_ADDR, outstanding=0, drop_cnt=0, FIFO empty, halt=0.
REQ-029 Reset asserted mid-transaction SHALL abandon all in-flight state immediately.
REQ-030 arvalid SHALL rise on the first clock edge after rst deasserts.

Verification
REQ-031 Reset release, arready=1, R returns 1 cycle later with rdata=32'h24010001 -> first AR araddr=32'hbfc00000, then out_valid, out_pc=32'hbfc00000, out_inst=32'h24010001.
REQ-032 decode_allowin=0 with DEPTH=4 -> at most 4 entries buffered plus in-flight; arvalid low when full; release drains 4 in order at one per cycle.
REQ-033 Redirect to 32'hbfc00100 with 2 reads outstanding and 1 AR pending -> drop_cnt=3, those 3 R beats discarded, first out_pc=32'hbfc00100.
REQ-034 rid=1 beats interleaved with fetch beats -> rready low for rid=1; fetch data order and PCs unaffected.
REQ-035 redirect_pc=32'hbfc00102 -> no AR issued, one entry out_adel=1, out_pc=32'hbfc00102, then no fetch until the next redirect.
REQ-036 rst pulsed low mid-burst -> arvalid=0 and out_valid=0 immediately; restart fetch at 32'hbfc00000.
